ex_result_buffer: RTL

Registered execute-to-memory handoff stage that sits directly downstream of the ALU. Each cycle it accepts the ALU result and flags together with destination-register info. It resolves the branch condition from the subtraction flags and holds everything in a 2-entry skid buffer under a valid/ready handshake. This makes the ALU's combinational path end at a register, and lets the memory stage stall without a combinational ready path back into execute.

---
 rtl/ex_result_buffer.sv | 93 +++++++++
 1 files changed

// File: rtl/ex_result_buffer.sv
// ex_result_buffer: registered ALU-to-memory handoff with branch resolution and a 2-entry skid buffer
module ex_result_buffer #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_result,
    input  logic                  in_zero,
    input  logic                  in_negative,
    input  logic                  in_overflow,
    input  logic                  in_carry,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_we,
    input  logic                  in_is_branch,
    input  logic [2:0]            in_br_funct3,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_result,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_reg_we,
    output logic                  out_br_taken,
    output logic [3:0]            out_flags,
    output logic [CNT_W-1:0]      stall_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    typedef struct packed {
        logic [WIDTH-1:0]      result;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  taken;
        logic [3:0]            flags;
    } entry_t;
    state_t state;
    entry_t main_q, skid_q, cap;
    logic base, cond, accept, pop;
    assign in_ready     = state != TWO;
    assign out_valid    = state != EMPTY;
    assign accept       = in_valid && in_ready;
    assign pop          = out_valid && out_ready;
    assign out_result   = main_q.result;
    assign out_rd       = main_q.rd;
    assign out_reg_we   = main_q.we;
    assign out_br_taken = main_q.taken;
    assign out_flags    = main_q.flags;
    // Odd funct3 values invert the even condition; 010/011 never branch
    always_comb begin
        base = in_br_funct3[2:1] == 2'b00 ? in_zero :
               in_br_funct3[2:1] == 2'b10 ? in_negative ^ in_overflow :
               in_br_funct3[2:1] == 2'b11 ? in_carry : 1'b0;
        cond = in_br_funct3[2:1] == 2'b01 ? 1'b0 : base ^ in_br_funct3[0];
        cap  = '{result: in_result,
                 rd:     in_rd,
                 we:     in_reg_we && !in_is_branch && in_rd != '0,
                 taken:  in_is_branch && cond,
                 flags:  {in_negative, in_zero, in_overflow, in_carry}};
    end
    // Occupancy state, head/skid storage and saturating stall counter; flush only empties
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            stall_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (flush)
                state <= EMPTY;
            else
                case (state)
                    EMPTY: if (accept) begin
                        state  <= ONE;
                        main_q <= cap;
                    end
                    ONE: if (accept && pop) main_q <= cap;
                    else if (accept) begin
                        state  <= TWO;
                        skid_q <= cap;
                    end else if (pop) state <= EMPTY;
                    TWO: if (pop) begin
                        state  <= ONE;
                        main_q <= skid_q;
                    end
                    default: state <= EMPTY;
                endcase
        end
    end
endmodule
